// File: rtl/riscv_lsu_if.sv
// Memory-side bus of the load-store unit: one registered word-aligned
// request with byte enables, completed by a single ready pulse.
interface riscv_lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // LSU side: issues requests, receives read data and completion
  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  // Memory side: accepts requests, returns read data and completion
  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit between a single-cycle RISC-V core data port and a
// word-organised data memory. The request is captured once on entry to
// BUSY, the core is stalled until memory reports ready, and the addressed
// byte/halfword/word is extracted and extended combinationally.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  riscv_lsu_if.master mem
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // Byte-lane enables; halfwords ignore addr[0], words ignore addr[1:0]
  function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B, SZ_BU: be = 4'b0001 << off;
      SZ_H, SZ_HU: be = 4'b0011 << {off[1], 1'b0};
      SZ_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lane carries it
  function automatic logic [31:0] f_lane_wd(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] lane;
    case (size)
      SZ_B:    lane = {4{wd[7:0]}};
      SZ_H:    lane = {2{wd[15:0]}};
      SZ_W:    lane = wd;
      default: lane = 32'h0000_0000;
    endcase
    return lane;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_load;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rd;
  logic        w_stall;

  // State register; reset always lands in IDLE, even mid-access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the capture strobe for the request registers
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (core_req_i) begin
          w_state_nxt = ST_BUSY;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem.mem_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request registers: captured once on IDLE->BUSY, held until next access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_be   <= 4'b0000;
      r_addr <= 32'h0000_0000;
      r_wd   <= 32'h0000_0000;
      r_off  <= 2'b00;
      r_size <= 3'd0;
    end else if (w_load) begin
      r_we   <= core_we_i;
      r_be   <= f_byte_en(core_size_i, core_addr_i[1:0]);
      r_addr <= {core_addr_i[31:2], 2'b00};
      r_wd   <= f_lane_wd(core_size_i, core_wd_i);
      r_off  <= core_addr_i[1:0];
      r_size <= core_size_i;
    end
  end

  // Load extraction from the returned word using the captured offset/size
  always_comb begin
    w_byte = mem.mem_rd_i[{r_off, 3'b000} +: 8];
    w_half = mem.mem_rd_i[{r_off[1], 4'b0000} +: 16];
    w_rd   = 32'h0000_0000;
    if (r_state == ST_BUSY) begin
      case (r_size)
        SZ_B:    w_rd = {{24{w_byte[7]}}, w_byte};
        SZ_BU:   w_rd = {24'h00_0000, w_byte};
        SZ_H:    w_rd = {{16{w_half[15]}}, w_half};
        SZ_HU:   w_rd = {16'h0000, w_half};
        SZ_W:    w_rd = mem.mem_rd_i;
        default: w_rd = 32'h0000_0000;
      endcase
    end else begin
      w_rd = 32'h0000_0000;
    end
  end

  // Core stall: pending request in IDLE, outstanding memory in BUSY
  always_comb begin
    w_stall = 1'b0;
    if (rst_i) begin
      w_stall = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_stall = core_req_i;
    end else begin
      w_stall = ~mem.mem_ready_i;
    end
  end

  assign core_rd_o      = w_rd;
  assign core_stall_o   = w_stall;
  assign mem.mem_req_o  = (r_state == ST_BUSY) & ~rst_i;
  assign mem.mem_we_o   = r_we;
  assign mem.mem_be_o   = r_be;
  assign mem.mem_addr_o = r_addr;
  assign mem.mem_wd_o   = r_wd;

endmodule
